fpu_wb_retire: RTL and testbench

- Writeback/retire stage directly downstream of the single-precision FPU execution unit.
- Captures each FPU instruction's destination register index at issue and pairs it with the unit's completion one cycle later.
- FPR-destination results go straight to the FP register file write port.
- GPR-destination results (compare, classify, float-to-int, move) are buffered in a FIFO and drained to the integer writeback port with a valid/ready handshake.
- Exception flags are accumulated into the sticky fcsr.fflags register.

---
 rtl/fpu_wb_retire_pkg.sv | 21 ++
 rtl/fpu_wb_fifo.sv | 70 +++++++
 rtl/fpu_wb_retire.sv | 150 +++++++++++++++
 tb/tb_fpu_wb_retire.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fpu_wb_retire_pkg.sv
// Shared definitions for the FPU writeback/retire stage.
//   - fflags bit positions (NV,DZ,OF,UF,NX = bits 4..0)
//   - GPR writeback FIFO entry layout {addr, data}
package fpu_wb_retire_pkg;

  localparam int unsigned FFLAG_W  = 5;
  localparam int unsigned FFLAG_NV = 4;
  localparam int unsigned FFLAG_DZ = 3;
  localparam int unsigned FFLAG_OF = 2;
  localparam int unsigned FFLAG_UF = 1;
  localparam int unsigned FFLAG_NX = 0;

  localparam int unsigned WB_AW = 5;
  localparam int unsigned WB_DW = 32;

  typedef struct packed {
    logic [WB_AW-1:0] addr;
    logic [WB_DW-1:0] data;
  } wb_entry_t;

endpackage

// File: rtl/fpu_wb_fifo.sv
// Synchronous FIFO buffering GPR-destination FPU results.
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   i_push/i_push_data  write request and entry
//   i_pop           read request (ignored when empty)
//   o_head          entry at the read pointer, straight from storage
//   o_count         occupancy, log2(DEPTH)+1 bits
//   o_full/o_empty  occupancy flags
//   o_drop          push discarded because full with no pop
module fpu_wb_fifo
  import fpu_wb_retire_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  localparam int unsigned PW   = $clog2(DEPTH),
  localparam int unsigned CW   = PW + 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            i_push,
  input  wb_entry_t       i_push_data,
  input  logic            i_pop,
  output wb_entry_t       o_head,
  output logic [CW-1:0]   o_count,
  output logic            o_full,
  output logic            o_empty,
  output logic            o_drop
);

  wb_entry_t     r_mem [DEPTH];
  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;

  logic w_pop;
  logic w_push;

  assign o_full  = (r_count == CW'(DEPTH));
  assign o_empty = (r_count == '0);
  assign o_count = r_count;
  assign o_head  = r_mem[r_rd_ptr];

  // A pop frees the slot in the same cycle, so push-while-full is legal
  // when paired with a pop.
  assign w_pop  = i_pop & ~o_empty;
  assign w_push = i_push & (~o_full | w_pop);
  assign o_drop = i_push & ~w_push;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_mem    <= '{default: '0};
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr] <= i_push_data;
        r_wr_ptr        <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/fpu_wb_retire.sv
// Writeback/retire stage behind the single-precision FPU.
// Ports:
//   clk, rst_l                 clock, synchronous reset (1 = asserted)
//   issue_valid/issue_rd       op accepted upstream and its destination
//   issue_stall                upstream must hold off issue
//   fpu_complete/_rd           completion, and whether it targets a GPR
//   fpu_result_1/fpu_result_rd FP and integer results
//   sflags                     exception flags, the cycle after completion
//   fpr_wr_*                   FP register file write port
//   gpr_wb_*                   integer writeback valid/ready port
//   csr_fflags_we/wdata        CSR write of fflags
//   fflags                     sticky accrued flags
//   orphan_err                 sticky protocol error
module fpu_wb_retire
  import fpu_wb_retire_pkg::*;
#(
  parameter int unsigned FPLEN = 32,
  parameter int unsigned DEPTH = 4,
  parameter int unsigned AW    = WB_AW   // must match the FIFO entry address width
) (
  input  logic               clk,
  input  logic               rst_l,
  input  logic               issue_valid,
  input  logic [AW-1:0]      issue_rd,
  output logic               issue_stall,
  input  logic               fpu_complete,
  input  logic               fpu_complete_rd,
  input  logic [FPLEN-1:0]   fpu_result_1,
  input  logic [31:0]        fpu_result_rd,
  input  logic [FFLAG_W-1:0] sflags,
  output logic               fpr_wr_en,
  output logic [AW-1:0]      fpr_wr_addr,
  output logic [FPLEN-1:0]   fpr_wr_data,
  output logic               gpr_wb_valid,
  input  logic               gpr_wb_ready,
  output logic [AW-1:0]      gpr_wb_addr,
  output logic [31:0]        gpr_wb_data,
  input  logic               csr_fflags_we,
  input  logic [FFLAG_W-1:0] csr_fflags_wdata,
  output logic [FFLAG_W-1:0] fflags,
  output logic               orphan_err
);

  localparam int unsigned CW = $clog2(DEPTH) + 1;

  logic               r_tag_v;
  logic [AW-1:0]      r_tag_rd;
  logic               r_fpr_we;
  logic [AW-1:0]      r_fpr_addr;
  logic [FPLEN-1:0]   r_fpr_data;
  logic               r_acc;
  logic [FFLAG_W-1:0] r_fflags;
  logic               r_orphan;

  logic               w_cmpl_ok;
  logic               w_orphan;
  logic               w_fpr_done;
  logic               w_gpr_push;
  logic               w_pop;
  logic               w_empty;
  logic               w_full;
  logic               w_drop;
  logic [CW-1:0]      w_count;
  logic [CW:0]        w_occ;
  wb_entry_t          w_push_entry;
  wb_entry_t          w_head;

  assign w_cmpl_ok  = fpu_complete & r_tag_v;
  assign w_orphan   = fpu_complete & ~r_tag_v;
  assign w_fpr_done = w_cmpl_ok & ~fpu_complete_rd;
  assign w_gpr_push = w_cmpl_ok & fpu_complete_rd;

  assign w_push_entry.addr = r_tag_rd;
  assign w_push_entry.data = fpu_result_rd;

  assign gpr_wb_valid = ~w_empty;
  assign w_pop        = gpr_wb_valid & gpr_wb_ready;
  assign gpr_wb_addr  = w_head.addr;
  assign gpr_wb_data  = w_head.data;

  // The in-flight tag will occupy a slot when it completes, so count it
  // as already resident; a legal push can then never meet a full FIFO.
  assign w_occ       = {1'b0, w_count} + (CW+1)'(r_tag_v);
  assign issue_stall = (w_occ >= (CW+1)'(DEPTH));

  assign fpr_wr_en   = r_fpr_we;
  assign fpr_wr_addr = r_fpr_addr;
  assign fpr_wr_data = r_fpr_data;
  assign fflags      = r_fflags;
  assign orphan_err  = r_orphan;

  fpu_wb_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk         (clk),
    .rst         (rst_l),
    .i_push      (w_gpr_push),
    .i_push_data (w_push_entry),
    .i_pop       (w_pop),
    .o_head      (w_head),
    .o_count     (w_count),
    .o_full      (w_full),
    .o_empty     (w_empty),
    .o_drop      (w_drop)
  );

  always_ff @(posedge clk) begin
    if (rst_l) begin
      r_tag_v    <= 1'b0;
      r_tag_rd   <= '0;
      r_fpr_we   <= 1'b0;
      r_fpr_addr <= '0;
      r_fpr_data <= '0;
      r_acc      <= 1'b0;
      r_fflags   <= '0;
      r_orphan   <= 1'b0;
    end else begin
      // A same-cycle issue wins over completion so back-to-back ops keep a tag.
      if (issue_valid) begin
        r_tag_v  <= 1'b1;
        r_tag_rd <= issue_rd;
      end else if (fpu_complete) begin
        r_tag_v  <= 1'b0;
      end

      r_fpr_we <= w_fpr_done;
      if (w_fpr_done) begin
        r_fpr_addr <= r_tag_rd;
        r_fpr_data <= fpu_result_1;
      end

      // sflags arrive one cycle after completion; r_acc marks that cycle.
      r_acc <= w_cmpl_ok;
      if (csr_fflags_we) begin
        r_fflags <= csr_fflags_wdata | (r_acc ? sflags : '0);
      end else if (r_acc) begin
        r_fflags <= r_fflags | sflags;
      end

      if (w_orphan | w_drop) begin
        r_orphan <= 1'b1;
      end
    end
  end

  // w_full is only needed inside the FIFO's drop decision.
  logic w_unused;
  assign w_unused = w_full;

endmodule

// File: tb/tb_fpu_wb_retire.sv
module tb_fpu_wb_retire;

  logic        clk = 1'b0;
  logic        rst_l = 1'b1;
  logic        issue_valid = 1'b0;
  logic [4:0]  issue_rd = '0;
  logic        issue_stall;
  logic        fpu_complete = 1'b0;
  logic        fpu_complete_rd = 1'b0;
  logic [31:0] fpu_result_1 = '0;
  logic [31:0] fpu_result_rd = '0;
  logic [4:0]  sflags = '0;
  logic        fpr_wr_en;
  logic [4:0]  fpr_wr_addr;
  logic [31:0] fpr_wr_data;
  logic        gpr_wb_valid;
  logic        gpr_wb_ready = 1'b0;
  logic [4:0]  gpr_wb_addr;
  logic [31:0] gpr_wb_data;
  logic        csr_fflags_we = 1'b0;
  logic [4:0]  csr_fflags_wdata = '0;
  logic [4:0]  fflags;
  logic        orphan_err;

  typedef struct packed {
    logic [4:0]  a;
    logic [31:0] d;
  } exp_t;

  exp_t sb[$];
  exp_t pend;
  bit   pend_v = 1'b0;
  int   n_tests = 0;
  int   n_fail = 0;

  fpu_wb_retire #(
    .FPLEN (32),
    .DEPTH (4),
    .AW    (5)
  ) dut (
    .clk              (clk),
    .rst_l            (rst_l),
    .issue_valid      (issue_valid),
    .issue_rd         (issue_rd),
    .issue_stall      (issue_stall),
    .fpu_complete     (fpu_complete),
    .fpu_complete_rd  (fpu_complete_rd),
    .fpu_result_1     (fpu_result_1),
    .fpu_result_rd    (fpu_result_rd),
    .sflags           (sflags),
    .fpr_wr_en        (fpr_wr_en),
    .fpr_wr_addr      (fpr_wr_addr),
    .fpr_wr_data      (fpr_wr_data),
    .gpr_wb_valid     (gpr_wb_valid),
    .gpr_wb_ready     (gpr_wb_ready),
    .gpr_wb_addr      (gpr_wb_addr),
    .gpr_wb_data      (gpr_wb_data),
    .csr_fflags_we    (csr_fflags_we),
    .csr_fflags_wdata (csr_fflags_wdata),
    .fflags           (fflags),
    .orphan_err       (orphan_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock: compare the FIFO head against the scoreboard before the edge,
  // then record any result driven this cycle as a new expected entry.
  task automatic cyc();
    exp_t e;
    #1;
    chk("gpr_valid", 64'(gpr_wb_valid), 64'(sb.size() != 0));
    if (gpr_wb_ready && sb.size() != 0) begin
      e = sb.pop_front();
      chk("gpr_addr", 64'(gpr_wb_addr), 64'(e.a));
      chk("gpr_data", 64'(gpr_wb_data), 64'(e.d));
    end
    @(posedge clk);
    #1;
    if (pend_v) begin
      sb.push_back(pend);
      pend_v = 1'b0;
    end
  endtask

  // Four pipelined GPR completions with back-to-back issue; ready held low.
  task automatic fill4(input logic [4:0] rd0, input logic [3:0][31:0] d);
    issue_valid = 1'b1;
    issue_rd    = rd0;
    cyc();
    for (int i = 0; i < 4; i++) begin
      fpu_complete    = 1'b1;
      fpu_complete_rd = 1'b1;
      fpu_result_rd   = d[i];
      pend.a          = rd0 + 5'(i);
      pend.d          = d[i];
      pend_v          = 1'b1;
      if (i < 3) begin
        issue_valid = 1'b1;
        issue_rd    = rd0 + 5'(i + 1);
      end else begin
        issue_valid = 1'b0;
      end
      cyc();
      chk("stall_fill", 64'(issue_stall), 64'(i >= 2));
    end
    fpu_complete    = 1'b0;
    fpu_complete_rd = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin
    repeat (2) @(posedge clk);
    #1;
    rst_l = 1'b0;
    chk("rst_fpr_en", 64'(fpr_wr_en), 64'(0));
    chk("rst_valid", 64'(gpr_wb_valid), 64'(0));
    chk("rst_fflags", 64'(fflags), 64'(0));
    chk("rst_orphan", 64'(orphan_err), 64'(0));
    chk("rst_stall", 64'(issue_stall), 64'(0));

    // FPR path: rd=3, fadd result 3.0
    issue_valid = 1'b1;
    issue_rd    = 5'd3;
    cyc();
    chk("stall_tag_only", 64'(issue_stall), 64'(0));
    issue_valid     = 1'b0;
    fpu_complete    = 1'b1;
    fpu_complete_rd = 1'b0;
    fpu_result_1    = 32'h4040_0000;
    cyc();
    fpu_complete = 1'b0;
    sflags       = 5'b00001;
    chk("fpr_en", 64'(fpr_wr_en), 64'(1));
    chk("fpr_addr", 64'(fpr_wr_addr), 64'(3));
    chk("fpr_data", 64'(fpr_wr_data), 64'h4040_0000);
    chk("fflags_early", 64'(fflags), 64'(0));
    cyc();
    sflags = '0;
    chk("fpr_en_once", 64'(fpr_wr_en), 64'(0));
    chk("fflags_acc", 64'(fflags), 64'(1));

    // Four feq results into the FIFO, then drain in order
    gpr_wb_ready = 1'b0;
    fill4(5'd1, {32'd0, 32'd1, 32'd0, 32'd1});
    cyc();
    chk("stall_full", 64'(issue_stall), 64'(1));
    gpr_wb_ready = 1'b1;
    repeat (4) cyc();
    chk("stall_drained", 64'(issue_stall), 64'(0));
    cyc();

    // Full FIFO: push and pop in the same cycle
    gpr_wb_ready = 1'b0;
    fill4(5'd5, {32'h53, 32'h52, 32'h51, 32'h50});
    issue_valid = 1'b1;
    issue_rd    = 5'd9;
    cyc();
    issue_valid     = 1'b0;
    fpu_complete    = 1'b1;
    fpu_complete_rd = 1'b1;
    fpu_result_rd   = 32'h0000_DEAD;
    pend.a          = 5'd9;
    pend.d          = 32'h0000_DEAD;
    pend_v          = 1'b1;
    gpr_wb_ready    = 1'b1;
    cyc();
    fpu_complete    = 1'b0;
    fpu_complete_rd = 1'b0;
    chk("stall_pushpop", 64'(issue_stall), 64'(1));
    chk("orphan_pushpop", 64'(orphan_err), 64'(0));
    repeat (4) cyc();
    cyc();
    chk("stall_after_dead", 64'(issue_stall), 64'(0));

    // CSR write colliding with accumulation
    issue_valid = 1'b1;
    issue_rd    = 5'd10;
    cyc();
    issue_valid  = 1'b0;
    fpu_complete = 1'b1;
    fpu_result_1 = 32'h3F80_0000;
    cyc();
    fpu_complete     = 1'b0;
    sflags           = 5'b10000;
    csr_fflags_we    = 1'b1;
    csr_fflags_wdata = 5'b00000;
    chk("fpr_addr_10", 64'(fpr_wr_addr), 64'(10));
    cyc();
    csr_fflags_we = 1'b0;
    sflags        = '0;
    chk("fflags_csr_acc", 64'(fflags), 64'(5'b10000));

    issue_valid = 1'b1;
    issue_rd    = 5'd12;
    cyc();
    issue_valid  = 1'b0;
    fpu_complete = 1'b1;
    cyc();
    fpu_complete = 1'b0;
    sflags       = 5'b00100;
    cyc();
    sflags = '0;
    chk("fflags_or", 64'(fflags), 64'(5'b10100));
    csr_fflags_we    = 1'b1;
    csr_fflags_wdata = 5'b00110;
    cyc();
    csr_fflags_we = 1'b0;
    chk("fflags_csr", 64'(fflags), 64'(5'b00110));

    // Orphan completions: no write, no push, no flag accrual
    fpu_complete    = 1'b1;
    fpu_complete_rd = 1'b0;
    cyc();
    fpu_complete = 1'b0;
    sflags       = 5'b01000;
    chk("orphan_set", 64'(orphan_err), 64'(1));
    chk("orphan_no_fpr", 64'(fpr_wr_en), 64'(0));
    cyc();
    sflags = '0;
    chk("orphan_no_acc", 64'(fflags), 64'(5'b00110));
    fpu_complete    = 1'b1;
    fpu_complete_rd = 1'b1;
    cyc();
    fpu_complete    = 1'b0;
    fpu_complete_rd = 1'b0;
    cyc();

    // Reset with two entries buffered and an op in flight
    gpr_wb_ready = 1'b0;
    issue_valid  = 1'b1;
    issue_rd     = 5'd11;
    cyc();
    for (int i = 0; i < 2; i++) begin
      fpu_complete    = 1'b1;
      fpu_complete_rd = 1'b1;
      fpu_result_rd   = 32'h11 + 32'(i);
      pend.a          = 5'd11 + 5'(i);
      pend.d          = 32'h11 + 32'(i);
      pend_v          = 1'b1;
      issue_valid     = 1'b1;
      issue_rd        = 5'd12 + 5'(i);
      cyc();
    end
    issue_valid     = 1'b0;
    fpu_complete    = 1'b0;
    fpu_complete_rd = 1'b0;
    chk("stall_pre_rst", 64'(issue_stall), 64'(0));
    rst_l = 1'b1;
    cyc();
    sb.delete();
    rst_l = 1'b0;
    chk("rst2_valid", 64'(gpr_wb_valid), 64'(0));
    chk("rst2_fpr_en", 64'(fpr_wr_en), 64'(0));
    chk("rst2_fflags", 64'(fflags), 64'(0));
    chk("rst2_stall", 64'(issue_stall), 64'(0));
    chk("rst2_orphan", 64'(orphan_err), 64'(0));
    fpu_complete = 1'b1;
    cyc();
    fpu_complete = 1'b0;
    chk("rst2_tag_dropped", 64'(orphan_err), 64'(1));
    chk("rst2_no_fpr", 64'(fpr_wr_en), 64'(0));
    cyc();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
